fpu_exc_status: RTL and testbench

//  Consumer end of the FPU exception-flag path: accumulates per-op flags {NV,DZ,OF,UF,NX} into a sticky status register.

---
 rtl/fpu_exc_status_pkg.sv | 37 +++
 rtl/fpu_exc_status_if.sv | 32 +++
 rtl/fpu_exc_status_sat_cnt.sv | 22 ++
 rtl/fpu_exc_status.sv | 128 ++++++++++++
 tb/tb_fpu_exc_status.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_exc_status_pkg.sv
// Shared types for the FPU exception-status block: flag indices, CSR op codes,
// trap FSM states and the CSR read-modify helper.
package fpu_exc_pkg;

    localparam int unsigned NFLAG  = 5;
    localparam int unsigned FLG_NV = 4;
    localparam int unsigned FLG_DZ = 3;
    localparam int unsigned FLG_OF = 2;
    localparam int unsigned FLG_UF = 1;
    localparam int unsigned FLG_NX = 0;

    typedef logic [NFLAG-1:0] flags_t;

    typedef enum logic [1:0] {
        CSR_READ  = 2'b00,
        CSR_WRITE = 2'b01,
        CSR_SET   = 2'b10,
        CSR_CLEAR = 2'b11
    } csr_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        GAP  = 2'b10
    } trap_state_e;

    // New register value produced by one CSR access
    function automatic flags_t csr_effect(csr_op_e op, flags_t cur, flags_t wdata);
        case (op)
            CSR_WRITE: return wdata;
            CSR_SET:   return cur | wdata;
            CSR_CLEAR: return cur & ~wdata;
            default:   return cur;
        endcase
    endfunction

endpackage

// File: rtl/fpu_exc_status_if.sv
// Retire-flag, CSR, trap and counter-read signals of fpu_exc_status.
// master = FPU/core side, slave = fpu_exc_status.
interface fpu_exc_status_if
    import fpu_exc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);
    logic             op_valid;
    logic [NFLAG-1:0] op_flags;
    logic             csr_req;
    logic [1:0]       csr_op;
    logic             csr_sel;
    logic [NFLAG-1:0] csr_wdata;
    logic [NFLAG-1:0] csr_rdata;
    logic             csr_ack;
    logic             trap_req;
    logic [NFLAG-1:0] trap_cause;
    logic             trap_ack;
    logic [2:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_rdata;

    modport master (
        output op_valid, op_flags, csr_req, csr_op, csr_sel, csr_wdata, trap_ack, cnt_sel,
        input  csr_rdata, csr_ack, trap_req, trap_cause, cnt_rdata
    );

    modport slave (
        input  op_valid, op_flags, csr_req, csr_op, csr_sel, csr_wdata, trap_ack, cnt_sel,
        output csr_rdata, csr_ack, trap_req, trap_cause, cnt_rdata
    );

endinterface

// File: rtl/fpu_exc_status_sat_cnt.sv
// Saturating event counter; a clear coincident with an increment leaves 1.
module fpu_exc_sat_cnt #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/fpu_exc_status.sv
// Sticky FPU exception flags, trap-enable mask, CSR port and trap req/ack handshake.
// Define EXC_COUNT_EN to add one saturating event counter per flag.
module fpu_exc_status
    import fpu_exc_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    fpu_exc_status_if.slave  bus
);

    flags_t      status_q, status_d;
    flags_t      mask_q, mask_d;
    flags_t      csr_rdata_q, csr_rdata_d;
    logic        csr_ack_q;
    logic        trap_req_q;
    flags_t      trap_cause_q;
    flags_t      pend_q;
    trap_state_e state_q;

    flags_t      new_flags;
    flags_t      trig;
    logic        csr_status;
    logic        csr_mask;
    csr_op_e     op;

    // Register updates; new op flags are ORed in last so they survive CLEAR/WRITE
    always_comb begin
        op          = csr_op_e'(bus.csr_op);
        new_flags   = bus.op_valid ? flags_t'(bus.op_flags) : '0;
        trig        = new_flags & mask_q;
        csr_status  = bus.csr_req && !bus.csr_sel;
        csr_mask    = bus.csr_req &&  bus.csr_sel;
        status_d    = (csr_status ? csr_effect(op, status_q, bus.csr_wdata) : status_q) | new_flags;
        mask_d      = csr_mask ? csr_effect(op, mask_q, bus.csr_wdata) : mask_q;
        csr_rdata_d = csr_rdata_q;
        if (bus.csr_req) begin
            csr_rdata_d = bus.csr_sel ? mask_q : status_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q    <= '0;
            mask_q      <= '0;
            csr_rdata_q <= '0;
            csr_ack_q   <= 1'b0;
        end else begin
            status_q    <= status_d;
            mask_q      <= mask_d;
            csr_rdata_q <= csr_rdata_d;
            csr_ack_q   <= bus.csr_req;
        end
    end

    // Trap handshake; GAP forces one low cycle between requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            trap_req_q   <= 1'b0;
            trap_cause_q <= '0;
            pend_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (trig != '0) begin
                        state_q      <= REQ;
                        trap_req_q   <= 1'b1;
                        trap_cause_q <= trig;
                    end
                end
                REQ: begin
                    pend_q <= pend_q | trig;
                    if (bus.trap_ack) begin
                        state_q    <= GAP;
                        trap_req_q <= 1'b0;
                    end
                end
                GAP: begin
                    if ((pend_q | trig) != '0) begin
                        state_q      <= REQ;
                        trap_req_q   <= 1'b1;
                        trap_cause_q <= pend_q | trig;
                        pend_q       <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.csr_rdata  = csr_rdata_q;
    assign bus.csr_ack    = csr_ack_q;
    assign bus.trap_req   = trap_req_q;
    assign bus.trap_cause = trap_cause_q;

`ifdef EXC_COUNT_EN
    logic [CNT_W-1:0] cnt [NFLAG];
    logic             cnt_clr_all;

    assign cnt_clr_all = csr_status && (op == CSR_CLEAR);

    for (genvar i = 0; i < int'(NFLAG); i++) begin : g_cnt
        fpu_exc_sat_cnt #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .inc   (bus.op_valid & bus.op_flags[i]),
            .clr   (cnt_clr_all & bus.csr_wdata[i]),
            .count (cnt[i])
        );
    end

    assign bus.cnt_rdata = (bus.cnt_sel < 3'(NFLAG)) ? cnt[bus.cnt_sel] : '0;
`else
    logic unused_cnt_sel;

    assign unused_cnt_sel = ^bus.cnt_sel;
    assign bus.cnt_rdata  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_fpu_exc_status.sv
// Directed self-checking bench for fpu_exc_status (counter section needs EXC_COUNT_EN).
module tb_fpu_exc_status;
    import fpu_exc_pkg::*;

`ifdef EXC_COUNT_EN
    localparam int unsigned CNT_W = 2;
`else
    localparam int unsigned CNT_W = 16;
`endif

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    fpu_exc_status_if #(.CNT_W(CNT_W)) bus ();

    fpu_exc_status #(.CNT_W(CNT_W)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drv_op(input logic v, input logic [4:0] f);
        bus.op_valid = v;
        bus.op_flags = f;
    endtask

    task automatic drv_csr(input logic req, input logic [1:0] op, input logic sel, input logic [4:0] wd);
        bus.csr_req   = req;
        bus.csr_op    = op;
        bus.csr_sel   = sel;
        bus.csr_wdata = wd;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drv_op(1'b0, 5'b0);
        drv_csr(1'b0, 2'b00, 1'b0, 5'b0);
        bus.trap_ack = 1'b0;
        bus.cnt_sel  = 3'd2;
        tick();
        tick();
        check("rst_rdata", 32'(bus.csr_rdata), 32'h0);
        check("rst_ack", 32'(bus.csr_ack), 32'h0);
        check("rst_trap_req", 32'(bus.trap_req), 32'h0);
        check("rst_cause", 32'(bus.trap_cause), 32'h0);
        check("rst_cnt", 32'(bus.cnt_rdata), 32'h0);
        rst_n = 1'b1;

        // Sticky accumulate, no trap with mask=0, then READ
        drv_op(1'b1, 5'b00100);
        tick();
        drv_op(1'b0, 5'b0);
        drv_csr(1'b1, 2'b00, 1'b0, 5'b0);
        check("t1_no_trap", 32'(bus.trap_req), 32'h0);
        tick();
        drv_csr(1'b0, 2'b00, 1'b0, 5'b0);
        check("t1_ack", 32'(bus.csr_ack), 32'h1);
        check("t1_rdata", 32'(bus.csr_rdata), 32'h04);
        tick();
        check("t1_ack_pulse", 32'(bus.csr_ack), 32'h0);

        // CLEAR all with a same-cycle NX op: new flag survives, read returns old
        drv_csr(1'b1, 2'b11, 1'b0, 5'b11111);
        drv_op(1'b1, 5'b00001);
        tick();
        drv_op(1'b0, 5'b0);
        check("t2_old", 32'(bus.csr_rdata), 32'h04);
        drv_csr(1'b1, 2'b00, 1'b0, 5'b0);
        tick();
        drv_csr(1'b0, 2'b00, 1'b0, 5'b0);
        check("t2_status", 32'(bus.csr_rdata), 32'h01);

        // Mask NV, trap held until acked
        drv_csr(1'b1, 2'b01, 1'b1, 5'b10000);
        tick();
        drv_csr(1'b0, 2'b00, 1'b0, 5'b0);
        check("t3_old_mask", 32'(bus.csr_rdata), 32'h0);
        drv_op(1'b1, 5'b10001);
        tick();
        drv_op(1'b0, 5'b0);
        check("t3_req", 32'(bus.trap_req), 32'h1);
        check("t3_cause", 32'(bus.trap_cause), 32'h10);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t3_held", 32'(bus.trap_req), 32'h1);
        end
        bus.trap_ack = 1'b1;
        tick();
        bus.trap_ack = 1'b0;
        check("t3_dropped", 32'(bus.trap_req), 32'h0);
        tick();
        check("t3_idle", 32'(bus.trap_req), 32'h0);
        bus.trap_ack = 1'b1;
        tick();
        bus.trap_ack = 1'b0;
        check("ack_in_idle", 32'(bus.trap_req), 32'h0);

        // Trig uses the current mask, not a same-cycle write
        drv_op(1'b1, 5'b10000);
        drv_csr(1'b1, 2'b11, 1'b1, 5'b11111);
        tick();
        drv_op(1'b0, 5'b0);
        drv_csr(1'b0, 2'b00, 1'b0, 5'b0);
        check("old_mask_traps", 32'(bus.trap_req), 32'h1);
        bus.trap_ack = 1'b1;
        tick();
        bus.trap_ack = 1'b0;
        tick();
        drv_op(1'b1, 5'b10000);
        drv_csr(1'b1, 2'b01, 1'b1, 5'b10000);
        tick();
        drv_op(1'b0, 5'b0);
        drv_csr(1'b0, 2'b00, 1'b0, 5'b0);
        check("new_mask_no_trap", 32'(bus.trap_req), 32'h0);

        // Second NV during REQ: GAP low cycle then re-request
        drv_op(1'b1, 5'b10000);
        tick();
        check("t4_req", 32'(bus.trap_req), 32'h1);
        tick();
        drv_op(1'b0, 5'b0);
        bus.trap_ack = 1'b1;
        tick();
        bus.trap_ack = 1'b0;
        check("t4_gap", 32'(bus.trap_req), 32'h0);
        tick();
        check("t4_rereq", 32'(bus.trap_req), 32'h1);
        check("t4_cause", 32'(bus.trap_cause), 32'h10);
        bus.trap_ack = 1'b1;
        tick();
        bus.trap_ack = 1'b0;
        tick();
        check("t4_idle", 32'(bus.trap_req), 32'h0);
        tick();
        check("t4_no_third", 32'(bus.trap_req), 32'h0);

        // Mask cleared while in REQ: pending trap still re-requests
        drv_op(1'b1, 5'b10000);
        tick();
        drv_csr(1'b1, 2'b11, 1'b1, 5'b11111);
        tick();
        drv_op(1'b0, 5'b0);
        drv_csr(1'b0, 2'b00, 1'b0, 5'b0);
        bus.trap_ack = 1'b1;
        tick();
        bus.trap_ack = 1'b0;
        tick();
        check("mclr_rereq", 32'(bus.trap_req), 32'h1);
        check("mclr_cause", 32'(bus.trap_cause), 32'h10);
        bus.trap_ack = 1'b1;
        tick();
        bus.trap_ack = 1'b0;
        tick();

        // Pend from ack cycle merges with trig arriving in GAP
        drv_csr(1'b1, 2'b01, 1'b1, 5'b11000);
        tick();
        drv_csr(1'b0, 2'b00, 1'b0, 5'b0);
        drv_op(1'b1, 5'b10000);
        tick();
        check("merge_cause1", 32'(bus.trap_cause), 32'h10);
        drv_op(1'b1, 5'b01000);
        bus.trap_ack = 1'b1;
        tick();
        bus.trap_ack = 1'b0;
        drv_op(1'b1, 5'b10000);
        tick();
        drv_op(1'b0, 5'b0);
        check("merge_req", 32'(bus.trap_req), 32'h1);
        check("merge_cause2", 32'(bus.trap_cause), 32'h18);

        // Async reset during REQ with pend set
        drv_op(1'b1, 5'b10000);
        tick();
        drv_op(1'b0, 5'b0);
        rst_n = 1'b0;
        #1;
        check("t5_req", 32'(bus.trap_req), 32'h0);
        check("t5_cause", 32'(bus.trap_cause), 32'h0);
        check("t5_rdata", 32'(bus.csr_rdata), 32'h0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_rereq", 32'(bus.trap_req), 32'h0);
        end

        // Back-to-back accesses with csr_req held
        drv_csr(1'b1, 2'b01, 1'b0, 5'b01010);
        tick();
        check("b2b_rd1", 32'(bus.csr_rdata), 32'h0);
        drv_csr(1'b1, 2'b00, 1'b0, 5'b0);
        tick();
        check("b2b_ack2", 32'(bus.csr_ack), 32'h1);
        check("b2b_rd2", 32'(bus.csr_rdata), 32'h0a);
        drv_csr(1'b1, 2'b10, 1'b0, 5'b00101);
        tick();
        drv_csr(1'b1, 2'b00, 1'b0, 5'b0);
        tick();
        drv_csr(1'b0, 2'b00, 1'b0, 5'b0);
        check("set_status", 32'(bus.csr_rdata), 32'h0f);

`ifdef EXC_COUNT_EN
        // Counter saturation, clear, and clear-with-increment
        drv_csr(1'b1, 2'b11, 1'b0, 5'b11111);
        tick();
        drv_csr(1'b0, 2'b00, 1'b0, 5'b0);
        drv_op(1'b1, 5'b00100);
        for (int i = 0; i < 5; i++) tick();
        drv_op(1'b0, 5'b0);
        bus.cnt_sel = 3'd2;
        #1;
        check("cnt_sat", 32'(bus.cnt_rdata), 32'h3);
        bus.cnt_sel = 3'd0;
        #1;
        check("cnt_other", 32'(bus.cnt_rdata), 32'h0);
        bus.cnt_sel = 3'd5;
        #1;
        check("cnt_sel_oob", 32'(bus.cnt_rdata), 32'h0);
        bus.cnt_sel = 3'd2;
        drv_csr(1'b1, 2'b11, 1'b0, 5'b00100);
        tick();
        drv_csr(1'b0, 2'b00, 1'b0, 5'b0);
        check("cnt_clr", 32'(bus.cnt_rdata), 32'h0);
        drv_op(1'b1, 5'b00100);
        tick();
        tick();
        drv_csr(1'b1, 2'b11, 1'b0, 5'b00100);
        tick();
        drv_csr(1'b0, 2'b00, 1'b0, 5'b0);
        drv_op(1'b0, 5'b0);
        check("cnt_clr_inc", 32'(bus.cnt_rdata), 32'h1);
`else
        drv_op(1'b1, 5'b00100);
        tick();
        drv_op(1'b0, 5'b0);
        check("cnt_tied0", 32'(bus.cnt_rdata), 32'h0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
